// File: rtl/time_counter_set.sv
// 24-hour BCD timekeeping core with a manual set mode and blink phase
// for the seven-segment display stage.
module time_counter_set #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk_100MHz,
    input  logic       rst_time,
    input  logic       set_en,
    input  logic       sel_next,
    input  logic       inc,
    output logic [3:0] L_sec,
    output logic [3:0] H_sec,
    output logic [3:0] L_min,
    output logic [3:0] H_min,
    output logic [3:0] L_hour,
    output logic [3:0] H_hour,
    output logic [1:0] select_time,
    output logic       change_out,
    output logic       tick_1hz
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int PW   = $clog2(CLK_HZ + 1);
    localparam int BW   = $clog2(HALF + 1);
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLK_TC = BW'(HALF - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          chg_q, chg_d;
    logic          tick_q, tick_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    ls_q, ls_d, hs_q, hs_d;
    logic [3:0]    lm_q, lm_d, hm_q, hm_d;
    logic [3:0]    lh_q, lh_d, hh_q, hh_d;

    // Wrapped +1 of each field, shared by tick carries and manual increment
    logic       sec_cy, min_cy, hr_wrap;
    logic [3:0] ls_inc, hs_inc, lm_inc, hm_inc, lh_inc, hh_inc;

    always_comb begin
        sec_cy  = (ls_q == 4'd9) && (hs_q == 4'd5);
        min_cy  = (lm_q == 4'd9) && (hm_q == 4'd5);
        hr_wrap = (hh_q == 4'd2) && (lh_q == 4'd3);
        ls_inc  = (ls_q == 4'd9) ? 4'd0 : ls_q + 4'd1;
        hs_inc  = hs_q;
        if (ls_q == 4'd9) hs_inc = (hs_q == 4'd5) ? 4'd0 : hs_q + 4'd1;
        lm_inc  = (lm_q == 4'd9) ? 4'd0 : lm_q + 4'd1;
        hm_inc  = hm_q;
        if (lm_q == 4'd9) hm_inc = (hm_q == 4'd5) ? 4'd0 : hm_q + 4'd1;
        if (hr_wrap) begin
            lh_inc = 4'd0;
            hh_inc = 4'd0;
        end else if (lh_q == 4'd9) begin
            lh_inc = 4'd0;
            hh_inc = hh_q + 4'd1;
        end else begin
            lh_inc = lh_q + 4'd1;
            hh_inc = hh_q;
        end
    end

    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        sel_d   = sel_q;
        ls_d = ls_q; hs_d = hs_q;
        lm_d = lm_q; hm_d = hm_q;
        lh_d = lh_q; hh_d = hh_q;
        if (!set_en) begin
            sel_d = 2'd0;
            if (presc_q == PRE_TC) begin
                presc_d = '0;
                tick_d  = 1'b1;
                ls_d = ls_inc; hs_d = hs_inc;
                if (sec_cy) begin
                    lm_d = lm_inc; hm_d = hm_inc;
                    if (min_cy) begin
                        lh_d = lh_inc; hh_d = hh_inc;
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = '0;
            if (inc) begin
                unique case (sel_q)
                    2'd0:    begin ls_d = ls_inc; hs_d = hs_inc; end
                    2'd1:    begin lm_d = lm_inc; hm_d = hm_inc; end
                    2'd2:    begin lh_d = lh_inc; hh_d = hh_inc; end
                    default: ;
                endcase
            end
            if (sel_next) sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
        end
    end

    // Blink counter free-runs regardless of mode
    always_comb begin
        blink_d = blink_q + BW'(1);
        phase_d = phase_q;
        if (blink_q == BLK_TC) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end
        chg_d = set_en & phase_d;
    end

    always_ff @(posedge clk_100MHz or posedge rst_time) begin
        if (rst_time) begin
            presc_q <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
            chg_q   <= 1'b0;
            tick_q  <= 1'b0;
            sel_q   <= 2'd0;
            ls_q <= '0; hs_q <= '0;
            lm_q <= '0; hm_q <= '0;
            lh_q <= '0; hh_q <= '0;
        end else begin
            presc_q <= presc_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            chg_q   <= chg_d;
            tick_q  <= tick_d;
            sel_q   <= sel_d;
            ls_q <= ls_d; hs_q <= hs_d;
            lm_q <= lm_d; hm_q <= hm_d;
            lh_q <= lh_d; hh_q <= hh_d;
        end
    end

    assign L_sec       = ls_q;
    assign H_sec       = hs_q;
    assign L_min       = lm_q;
    assign H_min       = hm_q;
    assign L_hour      = lh_q;
    assign H_hour      = hh_q;
    assign select_time = sel_q;
    assign change_out  = chg_q;
    assign tick_1hz    = tick_q;

endmodule

// File: tb/tb_time_counter_set.sv
// Directed bench for time_counter_set with CLK_HZ=20, BLINK_HZ=2.
// Each task drives one scenario and checks its own expected values.
module tb_time_counter_set;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_en = 1'b0;
    logic       sel_next = 1'b0;
    logic       inc = 1'b0;
    logic [3:0] L_sec, H_sec, L_min, H_min, L_hour, H_hour;
    logic [1:0] select_time;
    logic       change_out, tick_1hz;

    int tests = 0;
    int fails = 0;
    int ticks = 0;

    time_counter_set #(.CLK_HZ(20), .BLINK_HZ(2)) dut (
        .clk_100MHz (clk),
        .rst_time   (rst),
        .set_en     (set_en),
        .sel_next   (sel_next),
        .inc        (inc),
        .L_sec      (L_sec),
        .H_sec      (H_sec),
        .L_min      (L_min),
        .H_min      (H_min),
        .L_hour     (L_hour),
        .H_hour     (H_hour),
        .select_time(select_time),
        .change_out (change_out),
        .tick_1hz   (tick_1hz)
    );

    always #5 clk = ~clk;

    wire [23:0] hms = {H_hour, L_hour, H_min, L_min, H_sec, L_sec};

    task automatic step();
        @(posedge clk);
        #1;
        if (tick_1hz === 1'b1) ticks++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        inc = 1'b1;
        steps(n);
        inc = 1'b0;
    endtask

    task automatic pulse_sel();
        sel_next = 1'b1;
        step();
        sel_next = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        apply_reset();
        set_en = 1'b1;
        pulse_inc(s);
        pulse_sel();
        pulse_inc(m);
        pulse_sel();
        pulse_inc(h);
    endtask

    task automatic test_reset();
        set_en = 1'b0;
        rst = 1'b1;
        step();
        tests++;
        if (hms !== 24'h000000 || select_time !== 2'd0 || change_out !== 1'b0 ||
            tick_1hz !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: hms=%h sel=%0d chg=%b tick=%b, want 000000/0/0/0",
                     hms, select_time, change_out, tick_1hz);
        end
        rst = 1'b0;
        ticks = 0;
        steps(19);
        tests++;
        if (L_sec !== 4'd0 || ticks != 0) begin
            fail_pre: begin
                fails++;
                $display("FAIL pre_tick: L_sec=%0d ticks=%0d, want 0/0", L_sec, ticks);
            end
        end
        step();
        tests++;
        if (tick_1hz !== 1'b1 || L_sec !== 4'd1 || ticks != 1) begin
            fails++;
            $display("FAIL first_tick: tick=%b L_sec=%0d ticks=%0d, want 1/1/1",
                     tick_1hz, L_sec, ticks);
        end
        step();
        tests++;
        if (tick_1hz !== 1'b0) begin
            fails++;
            $display("FAIL tick_width: tick=%b, want 0", tick_1hz);
        end
    endtask

    task automatic test_rollover();
        set_time(23, 59, 58);
        tests++;
        if (hms !== 24'h235958 || select_time !== 2'd2) begin
            fails++;
            $display("FAIL set_235958: hms=%h sel=%0d, want 235958/2", hms, select_time);
        end
        set_en = 1'b0;
        ticks = 0;
        steps(20);
        tests++;
        if (hms !== 24'h235959 || ticks != 1 || select_time !== 2'd0) begin
            fails++;
            $display("FAIL run_235959: hms=%h ticks=%0d sel=%0d, want 235959/1/0",
                     hms, ticks, select_time);
        end
        steps(20);
        tests++;
        if (hms !== 24'h000000 || ticks != 2) begin
            fails++;
            $display("FAIL rollover: hms=%h ticks=%0d, want 000000/2", hms, ticks);
        end
    endtask

    task automatic test_hour_carry();
        set_time(9, 59, 59);
        set_en = 1'b0;
        steps(20);
        tests++;
        if (hms !== 24'h100000) begin
            fails++;
            $display("FAIL carry_0910: hms=%h, want 100000", hms);
        end
        set_time(19, 59, 59);
        set_en = 1'b0;
        steps(20);
        tests++;
        if (hms !== 24'h200000) begin
            fails++;
            $display("FAIL carry_1920: hms=%h, want 200000", hms);
        end
    endtask

    task automatic test_hour_wrap();
        apply_reset();
        set_en = 1'b1;
        ticks = 0;
        pulse_sel();
        pulse_sel();
        pulse_inc(23);
        tests++;
        if (hms !== 24'h230000 || select_time !== 2'd2) begin
            fails++;
            $display("FAIL hour_23: hms=%h sel=%0d, want 230000/2", hms, select_time);
        end
        pulse_inc(1);
        steps(30);
        tests++;
        if (hms !== 24'h000000 || ticks != 0) begin
            fails++;
            $display("FAIL hour_wrap: hms=%h ticks=%0d, want 000000/0", hms, ticks);
        end
    endtask

    task automatic test_blink();
        int last = -1;
        int n_chg = 0;
        int bad = 0;
        logic prev;
        set_en = 1'b1;
        steps(3);
        prev = change_out;
        for (int i = 0; i < 30; i++) begin
            step();
            if (change_out !== prev) begin
                if (last >= 0 && i - last != 5) bad++;
                last = i;
                n_chg++;
                prev = change_out;
            end
        end
        tests++;
        if (n_chg < 5 || bad != 0) begin
            fails++;
            $display("FAIL blink_period: changes=%0d bad_spacing=%0d, want >=5/0",
                     n_chg, bad);
        end
        while (change_out !== 1'b1 && last < 40) begin
            step();
            last++;
        end
        set_en = 1'b0;
        step();
        tests++;
        if (change_out !== 1'b0) begin
            fails++;
            $display("FAIL blink_off: chg=%b, want 0", change_out);
        end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (change_out !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL blink_idle: nonzero_cycles=%0d, want 0", bad);
        end
    endtask

    task automatic test_inc_sel_same();
        apply_reset();
        set_en = 1'b1;
        pulse_sel();
        pulse_inc(59);
        tests++;
        if (hms !== 24'h005900 || select_time !== 2'd1) begin
            fails++;
            $display("FAIL min_59: hms=%h sel=%0d, want 005900/1", hms, select_time);
        end
        inc = 1'b1;
        sel_next = 1'b1;
        step();
        inc = 1'b0;
        sel_next = 1'b0;
        tests++;
        if (hms !== 24'h000000 || select_time !== 2'd2) begin
            fails++;
            $display("FAIL inc_sel_same: hms=%h sel=%0d, want 000000/2", hms, select_time);
        end
        pulse_sel();
        tests++;
        if (select_time !== 2'd0) begin
            fails++;
            $display("FAIL sel_wrap: sel=%0d, want 0", select_time);
        end
    endtask

    task automatic test_ignore_run_mode();
        set_time(0, 0, 7);
        set_en = 1'b0;
        step();
        inc = 1'b1;
        sel_next = 1'b1;
        steps(4);
        inc = 1'b0;
        sel_next = 1'b0;
        step();
        tests++;
        if (hms !== 24'h000007 || select_time !== 2'd0) begin
            fails++;
            $display("FAIL ignore_run: hms=%h sel=%0d, want 000007/0", hms, select_time);
        end
    endtask

    task automatic test_reset_mid();
        set_time(12, 34, 56);
        tests++;
        if (hms !== 24'h123456) begin
            fails++;
            $display("FAIL set_123456: hms=%h, want 123456", hms);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (hms !== 24'h000000 || select_time !== 2'd0 || change_out !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: hms=%h sel=%0d chg=%b, want 000000/0/0",
                     hms, select_time, change_out);
        end
        inc = 1'b1;
        sel_next = 1'b1;
        steps(3);
        tests++;
        if (hms !== 24'h000000 || select_time !== 2'd0) begin
            fails++;
            $display("FAIL reset_hold: hms=%h sel=%0d, want 000000/0", hms, select_time);
        end
        inc = 1'b0;
        sel_next = 1'b0;
        rst = 1'b0;
        set_en = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_hour_carry();
        test_hour_wrap();
        test_blink();
        test_inc_sel_same();
        test_ignore_run_mode();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
